// File: rtl/int_seq_pkg.sv
// Shared CPU definitions for the interrupt sequencer: state encoding and
// low-byte vector addresses (the vector high byte is always FF).
package int_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_RST = 8'hFC;
  localparam logic [7:0] VEC_IRQ = 8'hFE;

  function automatic logic is_busy(input state_e st);
    return (st == ST_RESET) || (st == ST_SERVICE);
  endfunction

endpackage

// File: rtl/int_seq_sync_edge.sv
// Multi-flop input synchronizer; with EDGE_EN set, the output is instead a
// registered one-clock pulse on each rising edge of the synchronized level.
module sync_edge #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic y
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;
  logic              rise_r;
  logic              level_s;

  assign level_s = chain_r[STAGES-1];

  // synchronizer chain, edge history and registered edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= '0;
      prev_r  <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
      prev_r <= level_s;
      rise_r <= level_s & ~prev_r;
    end
  end

  assign y = EDGE_EN ? rise_r : level_s;

endmodule

// File: rtl/int_seq.sv
// 6502-style interrupt sequencer: arbitrates reset/NMI/IRQ/BRK at opcode
// fetch, forces the BRK sequence and supplies the vector low byte.
module int_seq
  import int_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       IRQ,
  input  logic       NMI,
  input  logic       I,
  input  logic       sync,
  input  logic       RDY,
  input  logic       brk_op,
  input  logic       ack,
  output logic       take,
  output logic [7:0] vec,
  output logic       B,
  output logic       busy
);

  state_e     state_r, state_nxt_s;
  logic [7:0] vec_r, vec_nxt_s;
  logic       b_r, b_nxt_s;
  logic       busy_r;
  logic       nmi_pend_r, nmi_pend_nxt_s;
  logic       nmi_seen_r, nmi_seen_nxt_s;
  logic       irq_sync_s, nmi_rise_s, irq_ok_s, take_s, done_s;

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_irq_sync (
    .clk (clk), .rst (RST), .d (IRQ), .y (irq_sync_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_nmi_sync (
    .clk (clk), .rst (RST), .d (NMI), .y (nmi_rise_s)
  );

  assign irq_ok_s = irq_sync_s & ~I;
  assign done_s   = RDY & ack & (state_r == ST_SERVICE);

  // source arbitration at the instruction boundary and service completion
  always_comb begin
    state_nxt_s = state_r;
    vec_nxt_s   = vec_r;
    b_nxt_s     = b_r;
    take_s      = 1'b0;
    if (RDY) begin
      case (state_r)
        ST_RESET: begin
          if (sync) begin
            take_s      = 1'b1;
            state_nxt_s = ST_SERVICE;
            vec_nxt_s   = VEC_RST;
            b_nxt_s     = 1'b0;
          end else begin
            state_nxt_s = ST_RESET;
          end
        end
        ST_RUN: begin
          if (sync && nmi_pend_r) begin
            take_s      = 1'b1;
            state_nxt_s = ST_SERVICE;
            vec_nxt_s   = VEC_NMI;
            b_nxt_s     = 1'b0;
          end else if (sync && irq_ok_s) begin
            take_s      = 1'b1;
            state_nxt_s = ST_SERVICE;
            vec_nxt_s   = VEC_IRQ;
            b_nxt_s     = 1'b0;
          end else if (sync && brk_op) begin
            // BRK is a real opcode, so it enters service without forcing
            state_nxt_s = ST_SERVICE;
            vec_nxt_s   = VEC_IRQ;
            b_nxt_s     = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_SERVICE: begin
          if (ack) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_SERVICE;
          end
        end
        default: begin
          state_nxt_s = ST_RESET;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // NMI pending flag; an edge seen during a service survives that service's ack
  always_comb begin
    nmi_pend_nxt_s = nmi_pend_r;
    nmi_seen_nxt_s = nmi_seen_r;
    if (done_s && (vec_r == VEC_NMI)) begin
      nmi_pend_nxt_s = nmi_rise_s | nmi_seen_r;
    end else if (nmi_rise_s) begin
      nmi_pend_nxt_s = 1'b1;
    end else begin
      nmi_pend_nxt_s = nmi_pend_r;
    end
    if (done_s) begin
      nmi_seen_nxt_s = 1'b0;
    end else if ((state_r == ST_SERVICE) && nmi_rise_s) begin
      nmi_seen_nxt_s = 1'b1;
    end else begin
      nmi_seen_nxt_s = nmi_seen_r;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r    <= ST_RESET;
      vec_r      <= VEC_RST;
      b_r        <= 1'b0;
      busy_r     <= 1'b1;
      nmi_pend_r <= 1'b0;
      nmi_seen_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      vec_r      <= vec_nxt_s;
      b_r        <= b_nxt_s;
      busy_r     <= is_busy(state_nxt_s);
      nmi_pend_r <= nmi_pend_nxt_s;
      nmi_seen_r <= nmi_seen_nxt_s;
    end
  end

  assign take = take_s & ~RST;
  assign vec  = vec_r;
  assign B    = b_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_int_seq.sv
// Randomized scoreboard bench for int_seq against a cycle-level reference
// model built from delay lines and the interrupt priority rules.
module tb_int_seq;

  logic       clk = 1'b0;
  logic       RST = 1'b1, IRQ = 1'b0, NMI = 1'b0, I = 1'b0;
  logic       sync = 1'b0, RDY = 1'b1, brk_op = 1'b0, ack = 1'b0;
  logic       take, B, busy;
  logic [7:0] vec;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] vec;
    logic       b;
    logic       busy;
  } exp_t;

  logic take_q[$];
  exp_t st_q[$];

  localparam int M_RESET = 0, M_RUN = 1, M_SVC = 2;
  int         m_st   = M_RESET;
  logic [7:0] m_vec  = 8'hFC;
  logic       m_b    = 1'b0;
  logic       m_pend = 1'b0;
  logic       m_seen = 1'b0;
  bit         nmi_h[4];
  bit         irq_h[2];

  int_seq #(.SYNC_STAGES(2)) dut (
    .clk (clk), .RST (RST), .IRQ (IRQ), .NMI (NMI), .I (I), .sync (sync),
    .RDY (RDY), .brk_op (brk_op), .ack (ack), .take (take), .vec (vec),
    .B (B), .busy (busy)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model predicts take for this cycle and the
  // registered outputs after the coming edge.
  task automatic cyc(input bit rst, input bit irq, input bit nmi, input bit iflag,
                     input bit sy, input bit rdy, input bit brk, input bit ak);
    bit   irq_s, rise, pend_n, seen_n, done;
    exp_t e;
    @(posedge clk);
    #2;
    RST = rst; IRQ = irq; NMI = nmi; I = iflag;
    sync = sy; RDY = rdy; brk_op = brk; ack = ak;
    // IRQ is seen two samples late; an NMI edge becomes pending three edges after it is sampled
    irq_s = irq_h[1];
    rise  = nmi_h[2] && !nmi_h[3];
    take_q.push_back(!rst && sy && rdy &&
                     (m_st == M_RESET || (m_st == M_RUN && (m_pend || (irq_s && !iflag)))));
    if (rst) begin
      m_st = M_RESET; m_vec = 8'hFC; m_b = 1'b0; m_pend = 1'b0; m_seen = 1'b0;
      for (int j = 0; j < 4; j++) nmi_h[j] = 1'b0;
      for (int j = 0; j < 2; j++) irq_h[j] = 1'b0;
    end else begin
      done   = rdy && ak && m_st == M_SVC;
      pend_n = (done && m_vec == 8'hFA) ? (rise || m_seen) : (m_pend || rise);
      seen_n = done ? 1'b0 : (m_seen || (m_st == M_SVC && rise));
      if (rdy) begin
        if (m_st == M_RESET && sy) begin
          m_st = M_SVC; m_vec = 8'hFC; m_b = 1'b0;
        end else if (m_st == M_RUN && sy) begin
          if (m_pend) begin
            m_st = M_SVC; m_vec = 8'hFA; m_b = 1'b0;
          end else if (irq_s && !iflag) begin
            m_st = M_SVC; m_vec = 8'hFE; m_b = 1'b0;
          end else if (brk) begin
            m_st = M_SVC; m_vec = 8'hFE; m_b = 1'b1;
          end
        end else if (m_st == M_SVC && ak) begin
          m_st = M_RUN;
        end
      end
      m_pend = pend_n;
      m_seen = seen_n;
      nmi_h[3] = nmi_h[2]; nmi_h[2] = nmi_h[1]; nmi_h[1] = nmi_h[0]; nmi_h[0] = nmi;
      irq_h[1] = irq_h[0]; irq_h[0] = irq;
    end
    e.vec  = m_vec;
    e.b    = m_b;
    e.busy = (m_st != M_RUN);
    st_q.push_back(e);
  endtask

  // Bursts with a sync every 4th clock and an ack two clocks later.
  task automatic run(input int n, input bit irq, input bit nmi, input bit iflag,
                     input int rdy_pct, input bit brk);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, irq, nmi, iflag, (k % 4) == 0, $urandom_range(99) < rdy_pct, brk, (k % 4) == 2);
    end
  endtask

  // take monitor, sampled mid-cycle while inputs are stable
  initial begin
    logic t;
    forever begin
      @(negedge clk);
      if (take_q.size() > 0) begin
        t = take_q.pop_front();
        checks++;
        if (take !== t) begin
          failures++;
          $display("FAIL take: got %0b expected %0b at %0t", take, t, $time);
        end
      end
    end
  end

  // registered output monitor, sampled just after the active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        checks += 3;
        if (vec !== e.vec) begin
          failures++;
          $display("FAIL vec: got %02h expected %02h at %0t", vec, e.vec, $time);
        end
        if (B !== e.b) begin
          failures++;
          $display("FAIL B: got %0b expected %0b at %0t", B, e.b, $time);
        end
        if (busy !== e.busy) begin
          failures++;
          $display("FAIL busy: got %0b expected %0b at %0t", busy, e.busy, $time);
        end
      end
    end
  end

  initial begin
    bit r_irq = 1'b0, r_nmi = 1'b0, r_i = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(12, 1'b0, 1'b0, 1'b0, 100, 1'b0);   // reset service
    run(16, 1'b1, 1'b0, 1'b0, 100, 1'b0);   // IRQ taken
    run(16, 1'b1, 1'b0, 1'b1, 100, 1'b0);   // IRQ masked
    run(12, 1'b0, 1'b0, 1'b0, 100, 1'b1);   // BRK
    run(4,  1'b0, 1'b0, 1'b0, 100, 1'b0);
    run(16, 1'b1, 1'b1, 1'b0, 100, 1'b0);   // NMI and IRQ together
    run(4,  1'b0, 1'b0, 1'b0, 100, 1'b0);
    run(50, 1'b0, 1'b1, 1'b0, 100, 1'b0);   // held NMI
    run(8,  1'b0, 1'b0, 1'b0, 100, 1'b0);
    run(20, 1'b0, 1'b1, 1'b0, 100, 1'b0);   // second NMI
    run(4,  1'b1, 1'b0, 1'b0, 100, 1'b0);
    run(24, 1'b1, 1'b0, 1'b0, 50,  1'b0);
    run(24, 1'b1, 1'b1, 1'b0, 50,  1'b0);   // NMI edge during IRQ service, RDY toggling
    run(4,  1'b0, 1'b0, 1'b0, 100, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(6,  1'b0, 1'b1, 1'b0, 100, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // reset mid-service
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run(16, 1'b0, 1'b1, 1'b0, 100, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19) == 0) r_irq = ~r_irq;
      if ($urandom_range(7) == 0)  r_nmi = ~r_nmi;
      if ($urandom_range(14) == 0) r_i   = ~r_i;
      cyc($urandom_range(149) == 0, r_irq, r_nmi, r_i, $urandom_range(2) == 0,
          $urandom_range(9) < 8, $urandom_range(3) == 0, $urandom_range(2) == 0);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (take_q.size() != 0 || st_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", take_q.size(), st_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_seq.md
INT_SEQ -- requirements
Module: int_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops on IRQ and NMI (legal 1..3).
REQ-002 clk  in  1  CPU clock; all state updates on posedge clk.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 IRQ  in  1  maskable interrupt request, level-sensitive, active-high.
REQ-005 NMI  in  1  non-maskable interrupt request, rising-edge-sensitive, active-high.
REQ-006 I  in  1  current processor I flag.
REQ-007 sync  in  1  instruction-boundary strobe from the control unit (opcode fetch cycle).
REQ-008 RDY  in  1  CPU ready; when low the block holds all state.
REQ-009 brk_op  in  1  opcode on DB at sync is BRK (00).
REQ-010 ack  in  1  control unit has fetched the vector low byte; service complete.
REQ-011 take  out  1  combinational: replace the fetched opcode with the forced BRK sequence this cycle.
REQ-012 vec  out  8  registered vector low address: FA (NMI), FC (reset), FE (IRQ/BRK); vector high is always FF.
REQ-013 B  out  1  registered B bit for the pushed status: 1 only for BRK.
REQ-014 busy  out  1  registered; high while in RESET or SERVICE state.

Function
REQ-015 The block SHALL implement three states: RESET, RUN, SERVICE.
REQ-016 IRQ and NMI SHALL each pass through SYNC_STAGES flops; the NMI edge detector compares the last stage with its previous value.
REQ-017 nmi_pend SHALL set on a synchronized NMI rising edge; with SYNC_STAGES=2 it is visible 3 clocks after the first posedge that samples NMI high.
REQ-018 A held-high NMI SHALL produce exactly one nmi_pend; a new edge requires NMI low for at least one synchronized sample.
REQ-019 irq_ok SHALL equal synchronized IRQ AND NOT I, evaluated in the sync cycle.
REQ-020 take SHALL equal sync AND RDY AND state==RUN AND (nmi_pend OR irq_ok); brk_op does not drive take.
REQ-021 In RUN, on sync AND RDY, the source SHALL be selected in priority NMI > IRQ > BRK; the block enters SERVICE with vec/B loaded (NMI: FA,0; IRQ: FE,0; BRK: FE,1).
REQ-022 In RUN, on sync AND RDY with no source selected, state SHALL remain RUN and vec/B SHALL be unchanged.
REQ-023 In RESET, the first sync AND RDY after RST has fallen SHALL load vec=FC, B=0, enter SERVICE, and assert take.
REQ-024 In SERVICE, vec and B SHALL hold stable; ack AND RDY SHALL return the state to RUN on the next clock.
REQ-025 On ack of an NMI service, nmi_pend SHALL clear, unless a new edge is detected in the same cycle, in which case it stays set.
REQ-026 An NMI edge during any SERVICE SHALL be latched and taken at the next qualifying sync in RUN.
REQ-027 Simultaneous NMI and IRQ SHALL select NMI; IRQ remains level-pending and is re-evaluated at the following sync.
REQ-028 ack outside SERVICE SHALL be ignored.
REQ-029 With RDY low, the state, nmi_pend, vec, and B SHALL hold, and take SHALL be 0; the synchronizers and edge detector keep running.

Reset
REQ-030 While RST is high, the block SHALL enter RESET and clear nmi_pend, the synchronizers, and the edge history.
REQ-031 Reset values SHALL be: take=0, vec=FC, B=0, busy=1.
REQ-032 RST asserted mid-SERVICE SHALL abandon the service, with the pending NMI discarded.

Structure
REQ-033 The state encoding and the vector constants FA/FC/FE SHALL live in the shared CPU package.
REQ-034 A single sub-module, sync_edge (parameterized synchronizer with optional rising-edge output), SHALL be instantiated for IRQ and NMI.

Verification
REQ-035 Scenario: RST for 4 clocks, then release; at the first sync with RDY=1 -> take=1, vec=FC, busy=1; ack -> busy=0 next clock.
REQ-036 Scenario: I=0 and IRQ=1 held; at sync -> take=1, vec=FE, B=0; with I=1 -> take=0 at every sync.
REQ-037 Scenario: brk_op=1 at sync with no interrupts -> take=0, vec=FE, B=1, enters SERVICE; ack returns to RUN.
REQ-038 Scenario: NMI and IRQ rise in the same clock, I=0 -> first service vec=FA; after ack, next sync -> vec=FE.
REQ-039 Scenario: NMI held high for 50 clocks across two syncs -> exactly one FA service; NMI low then high again -> a second FA service.
REQ-040 Scenario: NMI edge during an IRQ SERVICE with RDY toggling -> vec stays FE until ack; next sync -> vec=FA; RST mid-SERVICE -> vec=FC, nmi_pend=0.
